lstm_gate_scheduler: RTL and testbench

Timestep sequencer for the LSTM cell datapath. It launches the forget-gate and input-gate controllers concurrently, waits for both, then launches the output-gate controller. It repeats this for a host-programmed number of timesteps and strobes a hidden-state write at the end of each step. It sits between the host start/done handshake and the per-gate controllers: their `idle` input acts as the start pulse, and their `*_done` output is a level held high until the next `idle`.

---
 rtl/lstm_gate_scheduler_if.sv | 25 ++
 rtl/lstm_gate_scheduler.sv | 105 ++++++++++
 tb/tb_lstm_gate_scheduler.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/lstm_gate_scheduler_if.sv
// lstm_gate_scheduler_if: host handshake and gate-controller signals of the LSTM timestep scheduler.
interface lstm_gate_scheduler_if #(parameter int STEPS_W = 8);
  logic               start;
  logic               abort;
  logic [STEPS_W-1:0] num_steps;
  logic               f_done;
  logic               i_done;
  logic               o_done;
  logic               f_idle;
  logic               i_idle;
  logic               o_idle;
  logic               h_wr;
  logic [STEPS_W-1:0] step_idx;
  logic               busy;
  logic               done;
  logic               err;
  modport master (
    output start, abort, num_steps, f_done, i_done, o_done,
    input  f_idle, i_idle, o_idle, h_wr, step_idx, busy, done, err
  );
  modport slave (
    input  start, abort, num_steps, f_done, i_done, o_done,
    output f_idle, i_idle, o_idle, h_wr, step_idx, busy, done, err
  );
endinterface

// File: rtl/lstm_gate_scheduler.sv
// lstm_gate_scheduler: sequences forget/input gates, then output gate, for num_steps timesteps.
// Optional wait-state watchdog with sticky err is built when LSTM_SCHED_TIMEOUT_EN is defined.
module lstm_gate_scheduler #(
  parameter int STEPS_W        = 8,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TO_W           = 13
) (
  input logic                 clk,
  input logic                 rst,
  lstm_gate_scheduler_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LAUNCH_FI, WAIT_FI, LAUNCH_O, WAIT_O, STEP_END, FINISH} state_t;
  state_t             state_q, state_d;
  logic [STEPS_W-1:0] cnt_q, cnt_d, step_q, step_d;
  logic               f_seen_q, f_seen_d, i_seen_q, i_seen_d;
  logic               f_hit, i_hit, in_wait, wait_exit, to_fire;
  if ((1 << TO_W) <= TIMEOUT_CYCLES) begin : g_to_w_chk
    $error("TO_W too narrow for TIMEOUT_CYCLES");
  end
  assign f_hit     = f_seen_q | bus.f_done;
  assign i_hit     = i_seen_q | bus.i_done;
  assign in_wait   = (state_q == WAIT_FI) || (state_q == WAIT_O);
  assign wait_exit = (state_q == WAIT_FI) ? (f_hit && i_hit) : bus.o_done;
`ifdef LSTM_SCHED_TIMEOUT_EN
  logic [TO_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;
  assign to_fire = in_wait && !wait_exit && !bus.abort && (wd_q == TO_W'(TIMEOUT_CYCLES - 1));
  always_comb begin
    wd_d  = in_wait ? wd_q + TO_W'(1) : '0;
    err_d = (state_q == IDLE && bus.start) ? 1'b0 : (err_q | to_fire);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  assign bus.err = err_q;
`else
  assign to_fire = 1'b0;
  assign bus.err = 1'b0;
`endif
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    step_d   = step_q;
    f_seen_d = f_seen_q;
    i_seen_d = i_seen_q;
    case (state_q)
      IDLE: if (bus.start) begin
        cnt_d   = bus.num_steps;
        step_d  = '0;
        state_d = (bus.num_steps == '0) ? FINISH : LAUNCH_FI;
      end
      LAUNCH_FI: begin
        f_seen_d = 1'b0;
        i_seen_d = 1'b0;
        state_d  = WAIT_FI;
      end
      WAIT_FI: begin
        f_seen_d = f_hit;
        i_seen_d = i_hit;
        state_d  = wait_exit ? LAUNCH_O : WAIT_FI;
      end
      LAUNCH_O: state_d = WAIT_O;
      WAIT_O:   state_d = wait_exit ? STEP_END : WAIT_O;
      STEP_END: if (step_q == cnt_q - STEPS_W'(1)) state_d = FINISH;
      else begin
        step_d  = step_q + STEPS_W'(1);
        state_d = LAUNCH_FI;
      end
      FINISH:   state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    if (to_fire) state_d = IDLE;
    // abort outranks every transition including the watchdog
    if (bus.abort && state_q != IDLE) begin
      state_d = IDLE;
      step_d  = '0;
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      step_q   <= '0;
      f_seen_q <= 1'b0;
      i_seen_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      step_q   <= step_d;
      f_seen_q <= f_seen_d;
      i_seen_q <= i_seen_d;
    end
  assign bus.f_idle   = state_q == LAUNCH_FI;
  assign bus.i_idle   = state_q == LAUNCH_FI;
  assign bus.o_idle   = state_q == LAUNCH_O;
  assign bus.h_wr     = state_q == STEP_END;
  assign bus.done     = state_q == FINISH;
  assign bus.busy     = state_q != IDLE;
  assign bus.step_idx = step_q;
endmodule

// File: tb/tb_lstm_gate_scheduler.sv
// tb_lstm_gate_scheduler: table-driven and directed checks of the LSTM timestep scheduler.
module tb_lstm_gate_scheduler;
  localparam int W = 8;
  typedef struct {int ns; int df; int di; int d_o; int exp_p; int exp_done;} vec_t;
  logic clk = 0;
  logic rst = 0;
  always #5 clk = ~clk;
  lstm_gate_scheduler_if #(.STEPS_W(W)) bus();
  lstm_gate_scheduler #(.STEPS_W(W), .TIMEOUT_CYCLES(16), .TO_W(13)) dut (.clk(clk), .rst(rst), .bus(bus));
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int n_pass = 0, n_tot = 0;
  int f_dly = 1, i_dly = 1, o_dly = 1, f_t = 0, i_t = 0, o_t = 0;
  // gate models: done rises dly cycles after idle (0 = never), holds until the next idle
  always @(posedge clk or negedge rst)
    if (!rst) begin bus.f_done <= 0; f_t <= 0; end
    else if (bus.f_idle) begin bus.f_done <= (f_dly == 1); f_t <= (f_dly > 1) ? f_dly - 1 : 0; end
    else if (f_t > 0) begin f_t <= f_t - 1; if (f_t == 1) bus.f_done <= 1; end
  always @(posedge clk or negedge rst)
    if (!rst) begin bus.i_done <= 0; i_t <= 0; end
    else if (bus.i_idle) begin bus.i_done <= (i_dly == 1); i_t <= (i_dly > 1) ? i_dly - 1 : 0; end
    else if (i_t > 0) begin i_t <= i_t - 1; if (i_t == 1) bus.i_done <= 1; end
  always @(posedge clk or negedge rst)
    if (!rst) begin bus.o_done <= 0; o_t <= 0; end
    else if (bus.o_idle) begin bus.o_done <= (o_dly == 1); o_t <= (o_dly > 1) ? o_dly - 1 : 0; end
    else if (o_t > 0) begin o_t <= o_t - 1; if (o_t == 1) bus.o_done <= 1; end
  int n_f, n_i, n_o, n_h, n_d, n_busy, done_rel, s, fr, ir;
  int hidx[256];
  int gap[4], dlt[4];
  logic clr = 0, pf = 0, pi = 0;
  always @(negedge clk)
    if (clr) begin
      n_f = 0; n_i = 0; n_o = 0; n_h = 0; n_d = 0; n_busy = 0; done_rel = -1; fr = 0; ir = 0;
    end else begin
      if (bus.f_done && !pf) fr = cyc;
      if (bus.i_done && !pi) ir = cyc;
      pf = bus.f_done;
      pi = bus.i_done;
      if (bus.f_idle) n_f++;
      if (bus.i_idle) n_i++;
      if (bus.o_idle) begin
        if (n_o < 4) begin gap[n_o] = cyc - ((fr > ir) ? fr : ir); dlt[n_o] = ir - fr; end
        n_o++;
      end
      if (bus.h_wr) begin if (n_h < 256) hidx[n_h] = int'(bus.step_idx); n_h++; end
      if (bus.done) begin n_d++; done_rel = cyc - s; end
      if (bus.busy) n_busy++;
    end
  function automatic int outs();
    return int'({bus.f_idle, bus.i_idle, bus.o_idle, bus.h_wr, bus.busy, bus.done, bus.err, bus.step_idx});
  endfunction
  task automatic chk(input string nm, input int act, input int exp_v);
    n_tot++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
  endtask
  task automatic prep(input int df, input int di, input int d_o);
    f_dly = df; i_dly = di; o_dly = d_o;
    clr = 1;
    repeat (2) @(negedge clk);
    clr = 0;
    @(negedge clk);
  endtask
  task automatic start_run(input int ns);
    bus.num_steps = W'(ns);
    bus.start = 1;
    s = cyc;
    @(negedge clk);
    bus.start = 0;
  endtask
  task automatic wait_cyc(input int t);
    while (cyc - s < t) @(negedge clk);
  endtask
  task automatic wait_done(input string nm, input int limit);
    int k = 0;
    while (!bus.done && k < limit) begin @(negedge clk); k++; end
    chk({nm, "_done_seen"}, int'(bus.done), 1);
    repeat (2) @(negedge clk);
  endtask
  task automatic run(input string nm, input int ns, input int df, input int di, input int d_o);
    prep(df, di, d_o);
    start_run(ns);
    wait_done(nm, 4000);
  endtask
  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end
  vec_t tab[6];
  initial begin
    int bad, k, cnt;
    tab[0] = '{3, 10, 10, 10, 3, 70};
    tab[1] = '{0, 1, 1, 1, 0, 1};
    tab[2] = '{1, 1, 1, 1, 1, 6};
    tab[3] = '{2, 1, 3, 2, 2, 17};
    tab[4] = '{5, 2, 1, 1, 5, 31};
    tab[5] = '{255, 1, 1, 1, 255, 1276};
    bus.start = 0; bus.abort = 0; bus.num_steps = '0;
    repeat (2) @(negedge clk);
    chk("reset_outs", outs(), 0);
    rst = 1;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      run($sformatf("v%0d", i), tab[i].ns, tab[i].df, tab[i].di, tab[i].d_o);
      chk($sformatf("v%0d_f_idle", i), n_f, tab[i].exp_p);
      chk($sformatf("v%0d_i_idle", i), n_i, tab[i].exp_p);
      chk($sformatf("v%0d_o_idle", i), n_o, tab[i].exp_p);
      chk($sformatf("v%0d_h_wr", i), n_h, tab[i].exp_p);
      chk($sformatf("v%0d_done_cnt", i), n_d, 1);
      chk($sformatf("v%0d_done_cycle", i), done_rel, tab[i].exp_done);
      chk($sformatf("v%0d_busy_cycles", i), n_busy, tab[i].exp_done);
      chk($sformatf("v%0d_busy_after", i), int'(bus.busy), 0);
      bad = 0;
      for (int j = 0; j < tab[i].ns && j < 256; j++) if (hidx[j] != j) bad++;
      chk($sformatf("v%0d_h_step_idx", i), bad, 0);
    end
    prep(2, 22, 1);
    start_run(2);
    k = 0;
    while (!bus.o_idle && k < 200) begin @(negedge clk); k++; end
    i_dly = 2;
    wait_done("order", 400);
    chk("order_o_cnt", n_o, 2);
    chk("order_gap0", gap[0], 1);
    chk("order_gap1", gap[1], 1);
    chk("order_dlt0", dlt[0], 20);
    chk("order_dlt1", dlt[1], 0);
    prep(1, 1, 3);
    start_run(4);
    cnt = 0; k = 0;
    while (cnt < 2 && k < 200) begin @(negedge clk); k++; if (bus.o_idle) cnt++; end
    @(negedge clk);
    chk("abort_pre_idx", int'(bus.step_idx), 1);
    bus.abort = 1;
    @(negedge clk);
    bus.abort = 0;
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_idx", int'(bus.step_idx), 0);
    repeat (3) @(negedge clk);
    chk("abort_no_done", n_d, 0);
    chk("abort_h_wr", n_h, 1);
    run("after_abort", 1, 1, 1, 1);
    chk("after_abort_cycle", done_rel, 6);
    chk("after_abort_h_wr", n_h, 1);
    prep(5, 5, 1);
    start_run(2);
    wait_cyc(12);
    chk("rst_pre_busy", int'(bus.busy), 1);
    chk("rst_pre_idx", int'(bus.step_idx), 1);
    #2 rst = 0;
    #1 chk("rst_async_outs", outs(), 0);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    prep(1, 1, 1);
    start_run(2);
    wait_cyc(3);
    bus.num_steps = 8'd7;
    bus.start = 1;
    @(negedge clk);
    bus.start = 0;
    wait_done("ign_start", 200);
    chk("ign_start_cycle", done_rel, 11);
    chk("ign_start_h_wr", n_h, 2);
    chk("ign_start_f_idle", n_f, 2);
`ifdef LSTM_SCHED_TIMEOUT_EN
    prep(1, 1, 0);
    start_run(1);
    wait_cyc(19);
    chk("to_pre_busy", int'(bus.busy), 1);
    chk("to_pre_err", int'(bus.err), 0);
    wait_cyc(20);
    chk("to_busy", int'(bus.busy), 0);
    chk("to_err", int'(bus.err), 1);
    chk("to_idx_held", int'(bus.step_idx), 0);
    repeat (3) @(negedge clk);
    chk("to_no_done", n_d, 0);
    chk("to_err_sticky", int'(bus.err), 1);
    run("to_restart", 1, 1, 1, 1);
    chk("to_restart_err", int'(bus.err), 0);
    chk("to_restart_cycle", done_rel, 6);
`else
    prep(1, 1, 0);
    start_run(1);
    wait_cyc(1004);
    chk("noto_busy", int'(bus.busy), 1);
    chk("noto_err", int'(bus.err), 0);
    chk("noto_no_done", n_d, 0);
    bus.abort = 1;
    @(negedge clk);
    bus.abort = 0;
    chk("noto_abort_busy", int'(bus.busy), 0);
    chk("noto_abort_idx", int'(bus.step_idx), 0);
`endif
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
